// File: rtl/comparador_serial_der_izq.sv
// Serial magnitude comparator, LSB first: Z = (A<B) or (A<=B) chosen by modo, plus an equality flag.
// Latency: done pulses exactly N cycles after start is accepted; start in the done cycle is accepted back-to-back.
// Backpressure: none; start is ignored while busy, and operands are captured only on accept.
module comparador_serial_der_izq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         modo,
    output logic         busy,
    output logic         done,
    output logic         Z,
    output logic         igual
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [CW-1:0] cnt;
    logic          p;
    logic          eq;

    logic a_bit;
    logic b_bit;
    logic p_nxt;
    logic eq_nxt;

    assign a_bit  = sa[0];
    assign b_bit  = sb[0];
    // p carries "A<B so far" upward; a higher differing bit overrides the lower ones.
    assign p_nxt  = (p & (~a_bit | b_bit)) | (~a_bit & b_bit);
    assign eq_nxt = eq & ~(a_bit ^ b_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Z     <= 1'b0;
            igual <= 1'b0;
            cnt   <= '0;
            p     <= 1'b0;
            eq    <= 1'b0;
            sa    <= '0;
            sb    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= A;
                        sb    <= B;
                        p     <= modo;
                        eq    <= 1'b1;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    p   <= p_nxt;
                    eq  <= eq_nxt;
                    if (cnt == CNT_LAST) begin
                        // Wrap here so cnt never exceeds N-1 for non-power-of-two N.
                        cnt   <= '0;
                        Z     <= p_nxt;
                        igual <= eq_nxt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// Directed bench for comparador_serial_der_izq at N=8 with hand-computed expectations.
module tb_comparador_serial_der_izq;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         modo;
    logic         busy;
    logic         done;
    logic         z;
    logic         igual;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    comparador_serial_der_izq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .modo  (modo),
        .busy  (busy),
        .done  (done),
        .Z     (z),
        .igual (igual)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
    endtask

    task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic m, input logic ez, input logic eig);
        int k;
        a_in  = a;
        b_in  = b;
        modo  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Operand changes after accept must not affect the result.
        a_in  = ~a;
        b_in  = ~b;
        modo  = ~m;
        check({tag, ".busy"}, busy, 1);
        wait_done(k);
        check({tag, ".lat"}, k, 8);
        check({tag, ".z"}, z, ez);
        check({tag, ".igual"}, igual, eig);
        check({tag, ".busy_done"}, busy, 0);
        tick();
        check({tag, ".done_drop"}, done, 0);
        check({tag, ".z_hold"}, z, ez);
    endtask

    initial begin
        int k;
        int kd;
        int ndone;
        logic zs;
        logic igs;

        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        modo  = 1'b0;
        #2;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.z", z, 0);
        check("rst.igual", igual, 0);

        start = 1'b1;
        tick();
        tick();
        check("rst.start_ignored", busy, 0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();

        run_cmp("eq_lt", 8'h35, 8'h35, 1'b0, 1'b0, 1'b1);
        run_cmp("eq_le", 8'h35, 8'h35, 1'b1, 1'b1, 1'b1);
        run_cmp("msb_lt", 8'h7F, 8'h80, 1'b0, 1'b1, 1'b0);
        run_cmp("msb_le", 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0);
        run_cmp("lsb_le", 8'h13, 8'h12, 1'b1, 1'b0, 1'b0);
        run_cmp("lsb_lt", 8'h12, 8'h13, 1'b0, 1'b1, 1'b0);

        // Start pulse during a busy comparison is ignored.
        a_in  = 8'h05;
        b_in  = 8'h03;
        modo  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a_in  = 8'h01;
        b_in  = 8'h02;
        modo  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        k     = 3;
        ndone = 0;
        kd    = 0;
        zs    = 1'b1;
        igs   = 1'b1;
        while (k < 25) begin
            tick();
            k++;
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    kd  = k;
                    zs  = z;
                    igs = igual;
                end
            end
        end
        check("ign.ndone", ndone, 1);
        check("ign.lat", kd, 8);
        check("ign.z", zs, 0);
        check("ign.igual", igs, 0);

        // Leave Z=igual=1 so the async reset clear is observable.
        run_cmp("pre_rst", 8'h35, 8'h35, 1'b1, 1'b1, 1'b1);
        a_in  = 8'h01;
        b_in  = 8'h02;
        modo  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.busy", busy, 0);
        check("arst.done", done, 0);
        check("arst.z", z, 0);
        check("arst.igual", igual, 0);
        tick();
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        check("arst.no_done", ndone, 0);
        check("arst.idle", busy, 0);
        run_cmp("post_rst", 8'h12, 8'h13, 1'b0, 1'b1, 1'b0);

        // Start held high: back-to-back comparisons every 9 cycles.
        a_in  = 8'h01;
        b_in  = 8'h02;
        modo  = 1'b0;
        start = 1'b1;
        tick();
        wait_done(k);
        check("b2b.lat0", k, 8);
        check("b2b.z0", z, 1);
        for (int r = 1; r <= 3; r++) begin
            check("b2b.busy_in_done", busy, 0);
            tick();
            check("b2b.done_drop", done, 0);
            check("b2b.reaccept", busy, 1);
            wait_done(k);
            check("b2b.period", k + 1, 9);
            check("b2b.z", z, 1);
        end
        start = 1'b0;
        tick();
        check("b2b.stop_busy", busy, 0);
        check("b2b.stop_done", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
